// File: rtl/scale_weigh_controller.sv
// Weighing sequencer: settles raw gram samples, manages tare, drives the g->kg converter and holds its result.
// Optional overload detection is built when SCALE_OVERLOAD_DETECT_EN is defined.
module scale_weigh_controller #(
  parameter int W_G         = 14,
  parameter int INT_W       = 48,
  parameter int FRAC_W      = 51,
  parameter int STABLE_N    = 4,
  parameter int TOL         = 2,
  parameter int CONV_LAT    = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_G       = 10000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [W_G-1:0]    raw_grams,
  input  logic              tare_req,
  input  logic              measure_req,
  output logic [W_G-1:0]    conv_grams,
  input  logic [INT_W-1:0]  conv_kg_int,
  input  logic [FRAC_W-1:0] conv_kg_frac,
  output logic [INT_W-1:0]  kg_int,
  output logic [FRAC_W-1:0] kg_frac,
  output logic              result_valid,
  output logic              busy,
  output logic              stable,
  output logic [W_G-1:0]    tare_value,
  output logic              settle_timeout,
  output logic              overload
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]        state_q, state_d;
  logic              mode_tare_q, mode_tare_d;
  logic [W_G-1:0]    ref_q, ref_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [2:0]        lat_q, lat_d;
  logic [W_G-1:0]    tare_q, tare_d;
  logic [W_G-1:0]    conv_q, conv_d;
  logic [INT_W-1:0]  kg_int_q, kg_int_d;
  logic [FRAC_W-1:0] kg_frac_q, kg_frac_d;
  logic              valid_q, valid_d;
  logic              stable_q, stable_d;
  logic              tmo_q, tmo_d;
  logic              ovl_q, ovl_d;

  logic [W_G:0]      dev_w;
  logic              in_tol;
  logic [W_G-1:0]    ref_nxt;
  logic [3:0]        cnt_nxt;
  logic              stable_hit;
  logic [W_G:0]      net_w;

  // Stability tracking: a fresh reference restarts the run at 1.
  always_comb begin
    if (raw_grams >= ref_q) dev_w = {1'b0, raw_grams} - {1'b0, ref_q};
    else                    dev_w = {1'b0, ref_q} - {1'b0, raw_grams};
    in_tol = (dev_w <= (W_G+1)'(TOL));
    if (cnt_q == '0 || !in_tol) begin
      ref_nxt = raw_grams;
      cnt_nxt = 4'd1;
    end else begin
      ref_nxt = ref_q;
      cnt_nxt = cnt_q + 4'd1;
    end
    stable_hit = sample_valid && (cnt_nxt == 4'(STABLE_N));
    net_w      = {1'b0, ref_nxt} - {1'b0, tare_q};
  end

`ifdef SCALE_OVERLOAD_DETECT_EN
  always_comb begin
    ovl_d = ovl_q;
    if (sample_valid) ovl_d = ({1'b0, raw_grams} > (W_G+1)'(MAX_G));
  end
`else
  always_comb ovl_d = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mode_tare_d = mode_tare_q;
    ref_d       = ref_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    lat_d       = lat_q;
    tare_d      = tare_q;
    conv_d      = conv_q;
    kg_int_d    = kg_int_q;
    kg_frac_d   = kg_frac_q;
    valid_d     = valid_q;
    stable_d    = 1'b0;
    tmo_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tare_req || measure_req) begin
          state_d     = S_SETTLE;
          mode_tare_d = tare_req;
          valid_d     = 1'b0;
          cnt_d       = '0;
          tmr_d       = '0;
        end
      end
      S_SETTLE: begin
        tmr_d = tmr_q + 1'b1;
        if (sample_valid) begin
          ref_d = ref_nxt;
          cnt_d = cnt_nxt;
        end
        // Stability on the final cycle beats the timeout.
        if (stable_hit) begin
          stable_d = 1'b1;
          if (ovl_q) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end else if (mode_tare_q) begin
            tare_d  = ref_nxt;
            state_d = S_IDLE;
          end else begin
            conv_d  = net_w[W_G] ? '0 : net_w[W_G-1:0];
            lat_d   = '0;
            state_d = S_CONVERT;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CONVERT: begin
        lat_d = lat_q + 3'd1;
        if (lat_q == 3'(CONV_LAT - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        kg_int_d  = conv_kg_int;
        kg_frac_d = conv_kg_frac;
        valid_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_tare_q <= 1'b0;
      ref_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      lat_q       <= '0;
      tare_q      <= '0;
      conv_q      <= '0;
      kg_int_q    <= '0;
      kg_frac_q   <= '0;
      valid_q     <= 1'b0;
      stable_q    <= 1'b0;
      tmo_q       <= 1'b0;
      ovl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_tare_q <= mode_tare_d;
      ref_q       <= ref_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      lat_q       <= lat_d;
      tare_q      <= tare_d;
      conv_q      <= conv_d;
      kg_int_q    <= kg_int_d;
      kg_frac_q   <= kg_frac_d;
      valid_q     <= valid_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      ovl_q       <= ovl_d;
    end
  end

  assign conv_grams     = conv_q;
  assign kg_int         = kg_int_q;
  assign kg_frac        = kg_frac_q;
  assign result_valid   = valid_q;
  assign busy           = (state_q != S_IDLE);
  assign stable         = stable_q;
  assign tare_value     = tare_q;
  assign settle_timeout = tmo_q;
  assign overload       = ovl_q;

endmodule

// File: tb/tb_scale_weigh_controller.sv
// Scoreboard bench for scale_weigh_controller with a mock g->kg converter and a sample-list reference model.
module tb_scale_weigh_controller;

  localparam int W_G = 14, INT_W = 48, FRAC_W = 51;
  localparam int STABLE_N = 4, TOL = 2, CONV_LAT = 2, TIMEOUT_CYC = 1000, MAX_G = 10000;
  localparam logic [FRAC_W-1:0] FRAC_SCALE = 51'd2251799813685;

  localparam int EV_TARE = 0, EV_MEAS = 1, EV_RES = 2, EV_TMO = 3, EV_OVL = 4;

  logic clk = 1'b0;
  logic reset, sample_valid, tare_req, measure_req;
  logic [W_G-1:0]    raw_grams;
  logic [W_G-1:0]    conv_grams, tare_value;
  logic [INT_W-1:0]  conv_kg_int, kg_int;
  logic [FRAC_W-1:0] conv_kg_frac, kg_frac;
  logic result_valid, busy, stable, settle_timeout, overload;

  scale_weigh_controller #(
    .W_G(W_G), .INT_W(INT_W), .FRAC_W(FRAC_W), .STABLE_N(STABLE_N), .TOL(TOL),
    .CONV_LAT(CONV_LAT), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_G(MAX_G)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .raw_grams(raw_grams),
    .tare_req(tare_req), .measure_req(measure_req), .conv_grams(conv_grams),
    .conv_kg_int(conv_kg_int), .conv_kg_frac(conv_kg_frac), .kg_int(kg_int),
    .kg_frac(kg_frac), .result_valid(result_valid), .busy(busy), .stable(stable),
    .tare_value(tare_value), .settle_timeout(settle_timeout), .overload(overload)
  );

  // Mock combinational converter
  assign conv_kg_int  = {34'd0, conv_grams / 14'd1000};
  assign conv_kg_frac = 51'(conv_grams % 14'd1000) * FRAC_SCALE;

  always #5 clk = ~clk;

  typedef struct { int kind; int grams; int tare; } ev_t;
  ev_t exp_q[$];
  int  total = 0, bad = 0;
  int  cyc = 0, last_stable = 0;
  int  m_tare = 0;
  longint m_int = 0, m_frac = 0;
  int  smp_q[$];
  bit  rv_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic longint kg_i(input int g); return longint'(g / 1000); endfunction
  function automatic longint kg_f(input int g); return longint'(g % 1000) * longint'(FRAC_SCALE); endfunction

  // Monitor: pops expectations whenever the DUT signals an event.
  always @(negedge clk) begin
    ev_t e;
    if (reset) rv_prev = 1'b0;
    else begin
      if (stable) begin
        if (exp_q.size() == 0) chk("stable_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("stable_kind_ok", (e.kind == EV_TARE || e.kind == EV_MEAS || e.kind == EV_OVL) ? 1 : 0, 1);
          chk("stable_tare_value", tare_value, e.tare);
          if (e.kind == EV_MEAS) chk("stable_conv_grams", conv_grams, e.grams);
          last_stable = cyc;
        end
      end
      if (result_valid && !rv_prev) begin
        if (exp_q.size() == 0) chk("result_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("result_kind", e.kind, EV_RES);
          chk("kg_int", kg_int, kg_i(e.grams));
          chk("kg_frac", kg_frac, kg_f(e.grams));
          chk("result_latency", cyc - last_stable, CONV_LAT + 1);
        end
      end
      if (settle_timeout) begin
        if (exp_q.size() == 0) chk("timeout_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("timeout_kind", e.kind, EV_TMO);
          chk("timeout_tare_kept", tare_value, e.tare);
        end
      end
      rv_prev = result_valid;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) tick();
    chk("idle_within_bound", busy, 0);
  endtask

  // Reference: index of the sample completing a run of STABLE_N within TOL of the run's first sample.
  function automatic int stable_idx(output int refv);
    int start = 0;
    refv = 0;
    for (int i = 0; i < smp_q.size(); i++) begin
      int d = smp_q[i] - smp_q[start];
      if (d < 0) d = -d;
      if (i > 0 && d > TOL) start = i;
      if (i - start + 1 == STABLE_N) begin
        refv = smp_q[start];
        return i;
      end
    end
    return -1;
  endfunction

  // One operation: predict, request, feed samples up to the stabilising one.
  task automatic run_op(input bit is_tare, input bit both, input bit noise,
                        input bit ovl_case, input bit reset_mid);
    int refv, idx, net;
    idx = stable_idx(refv);
    if (ovl_case) exp_q.push_back('{EV_OVL, 0, m_tare});
    else if (is_tare) begin
      m_tare = refv;
      exp_q.push_back('{EV_TARE, 0, m_tare});
    end else begin
      net = (refv >= m_tare) ? refv - m_tare : 0;
      exp_q.push_back('{EV_MEAS, net, m_tare});
      if (!reset_mid) begin
        exp_q.push_back('{EV_RES, net, m_tare});
        m_int = kg_i(net); m_frac = kg_f(net);
      end
    end
    tare_req = is_tare | both; measure_req = !is_tare | both;
    tick();
    tare_req = 1'b0; measure_req = 1'b0;
    for (int i = 0; i <= idx; i++) begin
      if (noise && i == 1) begin
        tare_req = $urandom_range(0, 1); measure_req = !tare_req;
        tick();
        tare_req = 1'b0; measure_req = 1'b0;
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      raw_grams = W_G'(smp_q[i]); sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
    end
    if (reset_mid) begin
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_tare = 0; m_int = 0; m_frac = 0;
    end
    wait_idle(50);
    chk("result_valid_after_op", result_valid, (!is_tare && !both && !ovl_case && !reset_mid) ? 1 : 0);
  endtask

  task automatic set_const(input int v, input int n);
    smp_q.delete();
    for (int i = 0; i < n; i++) smp_q.push_back(v);
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; tare_req = 1'b0; measure_req = 1'b0; raw_grams = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_tare", tare_value, 0);
    chk("rst_conv", conv_grams, 0);
    chk("rst_kg_int", kg_int, 0);
    chk("rst_kg_frac", kg_frac, 0);
    chk("rst_flags", {stable, settle_timeout, overload}, 0);

    set_const(1500, 4); run_op(0, 0, 0, 0, 0);
    set_const(200, 4);  run_op(1, 0, 0, 0, 0);
    chk("tare_200", tare_value, 200);
    set_const(1700, 4); run_op(0, 0, 0, 0, 0);
    set_const(150, 4);  run_op(0, 0, 0, 0, 0);
    chk("sat_conv_zero", conv_grams, 0);
    set_const(0, 4);    run_op(1, 0, 0, 0, 0);
    smp_q = '{1000, 1001, 999, 1010, 1010, 1011, 1009, 1010};
    run_op(0, 0, 0, 0, 0);
    chk("jitter_conv", conv_grams, 1010);

    // Simultaneous requests: tare only
    set_const(321, 4); run_op(1, 1, 0, 0, 0);
    chk("both_tare", tare_value, 321);
    repeat (5) tick();
    chk("both_no_measure", busy, 0);

    for (int n = 0; n < 30; n++) begin
      int base = $urandom_range(1, 4000);
      smp_q.delete();
      for (int k = $urandom_range(0, 3); k > 0; k--) smp_q.push_back($urandom_range(0, 5000));
      for (int k = 0; k < STABLE_N; k++) smp_q.push_back(base + $urandom_range(0, 2) - 1);
      run_op(($urandom_range(0, 3) == 0), 0, $urandom_range(0, 1), 0, 0);
    end

    // Timeout with no samples: prior result must survive
    exp_q.push_back('{EV_TMO, 0, m_tare});
    measure_req = 1'b1; tick(); measure_req = 1'b0;
    wait_idle(TIMEOUT_CYC + 20);
    chk("tmo_result_valid", result_valid, 0);
    chk("tmo_kg_int_kept", kg_int, m_int);
    chk("tmo_kg_frac_kept", kg_frac, m_frac);

    set_const(2500, 4); run_op(0, 0, 1, 0, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valid", result_valid, 0);
    chk("rstmid_tare", tare_value, 0);
    chk("rstmid_kg_int", kg_int, 0);

`ifdef SCALE_OVERLOAD_DETECT_EN
    set_const(12000, 4); run_op(0, 0, 0, 1, 0);
    chk("ovl_set", overload, 1);
    chk("ovl_no_result", result_valid, 0);
    set_const(12000, 4); run_op(1, 0, 0, 1, 0);
    chk("ovl_tare_refused", tare_value, m_tare);
    raw_grams = 14'd5000; sample_valid = 1'b1; tick(); sample_valid = 1'b0;
    chk("ovl_cleared", overload, 0);
`else
    set_const(12000, 4); run_op(0, 0, 0, 0, 0);
    chk("ovl_tied_low", overload, 0);
`endif

    repeat (5) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scale_weigh_controller.md
Name: scale_weigh_controller

Overview:
- Sequences the grams-to-kilograms converter of the balance (scale) design.
- Takes raw load-cell samples in grams and waits for a stable reading. Manages the tare offset, feeds the net weight to the combinational converter, and latches the converter's kilogram integer/fraction outputs as a held result.
- Sits between the sample source / front-panel buttons and the display path.

Parameters:
- W_G, 14, width of gram values (raw, tare, net).
- INT_W, 48, width of converter kilogram-integer bus.
- FRAC_W, 51, width of converter kilogram-fraction bus.
- STABLE_N, 4, consecutive in-tolerance samples required for stability (1..15).
- TOL, 2, max absolute gram deviation from the reference sample still counted as stable.
- CONV_LAT, 2, clock cycles allowed for the converter before capture (1..7).
- TIMEOUT_CYC, 1000, cycles in SETTLE without stability before abort.
- MAX_G, 10000, overload threshold in grams (used only with the optional feature).

Ports:
- clk, in, 1, system clock, rising edge.
- reset, in, 1, synchronous, active-high.
- sample_valid, in, 1, one-cycle strobe: raw_grams holds a new sample.
- raw_grams, in, W_G, raw weight in grams.
- tare_req, in, 1, one-cycle request: capture stable reading as tare.
- measure_req, in, 1, one-cycle request: perform a net measurement.
- conv_grams, out, W_G, registered net grams driven to the converter.
- conv_kg_int, in, INT_W, converter integer-kilogram result.
- conv_kg_frac, in, FRAC_W, converter fractional-kilogram result.
- kg_int, out, INT_W, latched integer result.
- kg_frac, out, FRAC_W, latched fractional result.
- result_valid, out, 1, kg_int/kg_frac hold a valid measurement.
- busy, out, 1, high in any state other than IDLE.
- stable, out, 1, one-cycle pulse when stability is reached.
- tare_value, out, W_G, current tare offset.
- settle_timeout, out, 1, one-cycle pulse on SETTLE abort.
- overload, out, 1, overload flag (tied 0 without the optional feature).

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0, including tare_value, conv_grams, kg_int, kg_frac, result_valid and flags. Reset in any state aborts the operation; no partial result is kept.
- States: IDLE, SETTLE, CONVERT, DONE. Internal mode bit: TARE or MEASURE.
- IDLE:
  - tare_req -> SETTLE, mode=TARE.
  - else measure_req -> SETTLE, mode=MEASURE.
  - Both in the same cycle: tare wins; measure is dropped.
  - Either request clears result_valid on the next edge.
- SETTLE:
  - The first sample_valid loads ref=raw, cnt=1.
  - Each later sample with |raw-ref|<=TOL increments cnt. Otherwise ref=raw, cnt=1.
  - When cnt reaches STABLE_N: pulse stable.
    - mode TARE: tare_value<=ref, go to IDLE.
    - mode MEASURE: conv_grams<=ref-tare_value, saturating at 0 if ref<tare_value; go to CONVERT.
  - The cycle timer counts every cycle in SETTLE. On reaching TIMEOUT_CYC: pulse settle_timeout, go to IDLE, leave tare_value and result unchanged.
- CONVERT: conv_grams held constant; count CONV_LAT cycles, then go to DONE.
- DONE (one cycle): kg_int<=conv_kg_int, kg_frac<=conv_kg_frac, result_valid<=1, go to IDLE.
- result_valid and the result stay held until the next accepted request or reset.
- Requests arriving while busy are ignored (not queued).
- Latency: measure_req to result_valid = 1 + (cycles to collect STABLE_N stable samples) + CONV_LAT + 1.
- sample_valid is ignored outside SETTLE.
- Subtraction is performed at W_G+1 bits; the sign bit selects saturation.

Optional Feature:
- Macro SCALE_OVERLOAD_DETECT_EN.
- Defined: overload is registered high whenever a sample_valid arrives with raw_grams>MAX_G, and low on the next sample with raw_grams<=MAX_G.
  - While overload=1, a SETTLE in MEASURE mode does not go to CONVERT on reaching stability. Instead it goes to IDLE with result_valid=0.
  - Tare is also refused: tare_value is unchanged.
- Undefined: overload is constant 0, no comparator is built, and MAX_G is unused.

Test Plan:
- Basic measure: tare 0, STABLE_N=4, 4 samples of 1500 after measure_req -> stable pulse, conv_grams=1500, result_valid=1 after CONV_LAT+1 more cycles, kg outputs equal the converter's 1500 g result.
- Tare: tare_req with 4 samples of 200 -> tare_value=200. Then measure with samples of 1700 -> conv_grams=1500. Measure with samples of 150 -> conv_grams=0 (saturated).
- Jitter and restart: samples 1000,1001,999,1010,1010,1011,1009,1010 with TOL=2 -> stability only after the 1010-based run, conv_grams=1010.
- Timeout and priority: measure_req with no sample_valid for 1000 cycles -> settle_timeout pulse, IDLE, prior result kept. tare_req and measure_req in the same cycle -> tare performed only.
- Reset mid-operation: assert reset during CONVERT -> next cycle state IDLE, busy=0, result_valid=0, tare_value=0. Requests during busy are ignored.
- Macro defined: samples of 12000 with MAX_G=10000 -> overload=1, no result, tare refused. A sample of 5000 clears overload.
